// File: rtl/led_blink_ctrl.sv
// Multi-channel LED controller: per-channel off/on/blink/PWM modes configured
// through a single-cycle write port, sharing one blink timebase and one PWM counter.
module led_blink_ctrl #(
  parameter int NCH         = 3,
  parameter int TICK_DIV    = 12000,
  parameter int BLINK_TICKS = 250,
  parameter int PWM_BITS    = 8,
  parameter int ACTIVE_LOW  = 0,
  localparam int CHW        = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_wr,
  input  logic [CHW-1:0]      cfg_ch,
  input  logic [1:0]          cfg_mode,
  input  logic [PWM_BITS-1:0] cfg_duty,
  output logic                cfg_err,
  output logic                blink,
  output logic [NCH-1:0]      led
);

  localparam int   PSW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int   TCW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic POL = (ACTIVE_LOW != 0);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_ON    = 2'b01,
    MODE_BLINK = 2'b10,
    MODE_PWM   = 2'b11
  } mode_t;

  logic [PSW-1:0]      presc;
  logic [TCW-1:0]      tick_cnt;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                phase;
  mode_t               mode [NCH];
  logic [PWM_BITS-1:0] duty [NCH];

  logic           tick;
  logic           wrap;
  logic           phase_nxt;
  logic           ch_ok;
  logic [NCH-1:0] raw;

  // Blinking channels are driven from the phase value being registered this
  // edge, so led and blink change together and stay phase-locked.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    raw       = '0;
    tick      = (presc == PSW'(TICK_DIV - 1));
    wrap      = tick && (tick_cnt == TCW'(BLINK_TICKS - 1));
    phase_nxt = phase ^ wrap;
    ch_ok     = (int'(cfg_ch) < NCH);
    for (int i = 0; i < NCH; i++) begin
      case (mode[i])
        MODE_OFF:   raw[i] = 1'b0;
        MODE_ON:    raw[i] = 1'b1;
        MODE_BLINK: raw[i] = phase_nxt;
        MODE_PWM:   raw[i] = (pwm_cnt < duty[i]);
        default:    raw[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (reset) begin
      presc    <= '0;
      tick_cnt <= '0;
      pwm_cnt  <= '0;
      phase    <= 1'b0;
      cfg_err  <= 1'b0;
      led      <= {NCH{POL}};
    end else begin
      presc    <= tick ? '0 : presc + PSW'(1);
      if (tick) tick_cnt <= wrap ? '0 : tick_cnt + TCW'(1);
      pwm_cnt  <= pwm_cnt + PWM_BITS'(1);
      phase    <= phase_nxt;
      cfg_err  <= cfg_wr && !ch_ok;
      led      <= raw ^ {NCH{POL}};
    end
  end

  assign blink = phase;

  // NOTE: the mode/duty register file is explicitly reset because a freshly reset board must show all LEDs off.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        mode[i] <= MODE_OFF;
        duty[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (cfg_wr && (cfg_ch == CHW'(i))) begin
          mode[i] <= mode_t'(cfg_mode);
          duty[i] <= cfg_duty;
        end
      end
    end
  end

endmodule

// File: tb/tb_led_blink_ctrl.sv
// Directed bench for led_blink_ctrl: two instances (active-high and active-low
// pins) share one stimulus stream; expectations are hand-derived from edge counts.
module tb_led_blink_ctrl;

  localparam int NCH  = 3;
  localparam int TD   = 4;
  localparam int BT   = 2;
  localparam int PB   = 3;
  localparam int HALF = TD * BT;

  logic          clk = 1'b0;
  logic          reset;
  logic          cfg_wr;
  logic [1:0]    cfg_ch;
  logic [1:0]    cfg_mode;
  logic [PB-1:0] cfg_duty;

  logic           cfg_err, blink;
  logic [NCH-1:0] led;
  logic           cfg_err_n, blink_n;
  logic [NCH-1:0] led_n;

  int errors = 0;
  int checks = 0;
  int e;
  int highs;
  int n;

  led_blink_ctrl #(.NCH(NCH), .TICK_DIV(TD), .BLINK_TICKS(BT), .PWM_BITS(PB), .ACTIVE_LOW(0)) dut (
    .clk(clk), .reset(reset), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
    .cfg_duty(cfg_duty), .cfg_err(cfg_err), .blink(blink), .led(led)
  );

  led_blink_ctrl #(.NCH(NCH), .TICK_DIV(TD), .BLINK_TICKS(BT), .PWM_BITS(PB), .ACTIVE_LOW(1)) dut_n (
    .clk(clk), .reset(reset), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
    .cfg_duty(cfg_duty), .cfg_err(cfg_err_n), .blink(blink_n), .led(led_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", tag, e, got, exp);
    end
  endtask

  // Blink level after post-release edge k: toggles every HALF edges, first high at HALF.
  function automatic logic blink_exp(input int k);
    return ((k / HALF) % 2) == 1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    e++;
  endtask

  task automatic do_write(input logic [1:0] ch, input logic [1:0] mode, input logic [PB-1:0] duty);
    cfg_wr   = 1'b1;
    cfg_ch   = ch;
    cfg_mode = mode;
    cfg_duty = duty;
    step();
    cfg_wr   = 1'b0;
  endtask

  initial begin
    e        = 0;
    reset    = 1'b1;
    cfg_wr   = 1'b1;
    cfg_ch   = 2'd0;
    cfg_mode = 2'b01;
    cfg_duty = '0;

    // Reset with a concurrent write: write must be dropped.
    repeat (3) begin
      step();
      check("rst_led", led, 3'b000);
      check("rst_led_n", led_n, 3'b111);
      check("rst_blink", blink, 1'b0);
      check("rst_err", cfg_err, 1'b0);
    end
    reset  = 1'b0;
    cfg_wr = 1'b0;
    e      = 0;
    step();
    check("drop_led", led, 3'b000);
    check("drop_led_n", led_n, 3'b111);

    // Blink on ch1 (write accepted at edge 2).
    do_write(2'd1, 2'b10, '0);
    while (e < 40) begin
      step();
      check("blink_out", blink, blink_exp(e));
      check("blink_led1", led[1], blink_exp(e));
    end
    check("blink_n_out", blink_n, blink_exp(e));
    check("blink_led1_n", led_n[1], !blink_exp(e));

    // PWM duty 3 on ch2: pwm_cnt of cycle e-1 is (e-1) mod 8.
    do_write(2'd2, 2'b11, 3'd3);
    highs = 0;
    repeat (16) begin
      step();
      check("pwm3", led[2], ((e - 1) % 8) < 3);
      if (led[2]) highs++;
    end
    check("pwm3_count", highs, 6);

    do_write(2'd2, 2'b11, 3'd0);
    repeat (8) begin
      step();
      check("pwm0", led[2], 1'b0);
    end

    do_write(2'd2, 2'b11, 3'd7);
    highs = 0;
    repeat (8) begin
      step();
      check("pwm7", led[2], ((e - 1) % 8) < 7);
      if (led[2]) highs++;
    end
    check("pwm7_count", highs, 7);

    do_write(2'd2, 2'b00, '0);
    step();
    check("ch2_off", led[2], 1'b0);

    // Single-cycle on pulse on ch0: on, then off on the next cycle.
    cfg_wr   = 1'b1;
    cfg_ch   = 2'd0;
    cfg_mode = 2'b01;
    step();
    check("pulse_pre", led[0], 1'b0);
    check("pulse_pre_n", led_n[0], 1'b1);
    cfg_mode = 2'b00;
    step();
    cfg_wr = 1'b0;
    check("pulse_hi", led[0], 1'b1);
    check("pulse_hi_n", led_n[0], 1'b0);
    step();
    check("pulse_lo", led[0], 1'b0);
    check("pulse_lo_n", led_n[0], 1'b1);

    // Invalid channel write.
    cfg_wr   = 1'b1;
    cfg_ch   = 2'd3;
    cfg_mode = 2'b01;
    cfg_duty = 3'd7;
    step();
    cfg_wr = 1'b0;
    check("err_hi", cfg_err, 1'b1);
    check("err_hi_n", cfg_err_n, 1'b1);
    check("err_led", led, {1'b0, blink_exp(e), 1'b0});
    step();
    check("err_lo", cfg_err, 1'b0);
    check("err_led2", led, {1'b0, blink_exp(e), 1'b0});
    step();
    check("err_led3", led, {1'b0, blink_exp(e), 1'b0});

    // Back-to-back writes to ch0 and ch1.
    cfg_wr   = 1'b1;
    cfg_ch   = 2'd0;
    cfg_mode = 2'b01;
    cfg_duty = '0;
    step();
    cfg_ch = 2'd1;
    step();
    cfg_wr = 1'b0;
    check("b2b_err", cfg_err, 1'b0);
    step();
    step();
    check("b2b_led", led, 3'b011);
    check("b2b_led_n", led_n, 3'b100);

    // Reset mid-blink while blink is high.
    do_write(2'd1, 2'b10, '0);
    step();
    n = 0;
    while (!blink_exp(e) && n < 20) begin
      step();
      n++;
    end
    check("mid_wait", blink_exp(e), 1'b1);
    check("mid_pre_blink", blink, 1'b1);
    check("mid_pre_led1", led[1], 1'b1);
    reset = 1'b1;
    step();
    check("mid_rst_led", led, 3'b000);
    check("mid_rst_led_n", led_n, 3'b111);
    check("mid_rst_blink", blink, 1'b0);
    reset = 1'b0;
    e     = 0;
    repeat (20) begin
      step();
      check("post_led", led, 3'b000);
      check("post_blink", blink, blink_exp(e));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
